tug_field: RTL and testbench

Parametrised tug-of-war playfield. It replaces the per-LED light cells with one positional register that drives an arbitrary odd number of lights, detects wins, and keeps per-player round scores with a match-point limit. It sits between the player-input conditioning (edge-detected key pulses, CPU/LFSR opponent) and the LED/HEX display drivers.

---
 rtl/tug_field.sv | 131 +++++++++++++
 tb/tb_tug_field.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tug_field.sv
// Tug-of-war playfield: one position register drives the lights, detects round wins,
// keeps per-player scores and ends the match at a fixed number of round wins.
module tug_field #(
    parameter int unsigned NUM_LIGHTS   = 9,
    parameter int unsigned SCORE_W      = 3,
    parameter int unsigned MATCH_POINTS = 7,
    parameter int unsigned HOLD_CYCLES  = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  L,
    input  logic                  R,
    input  logic                  restartGame,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic [1:0]            winner,
    output logic [SCORE_W-1:0]    scoreL,
    output logic [SCORE_W-1:0]    scoreR,
    output logic                  matchOver
);

    localparam int unsigned POS_W  = $clog2(NUM_LIGHTS);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [POS_W-1:0]   CENTER    = POS_W'((NUM_LIGHTS - 1) / 2);
    localparam logic [POS_W-1:0]   LAST      = POS_W'(NUM_LIGHTS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] MATCH_V   = SCORE_W'(MATCH_POINTS);
    localparam logic [HOLD_W-1:0]  HOLD_V    = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [1:0] {StPlay, StWon, StMatch} state_e;

    state_e             state_q;
    logic [POS_W-1:0]   pos_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [SCORE_W-1:0] score_l_q, score_r_q;
    logic [1:0]         winner_q;

    logic               move_l, move_r;
    logic [SCORE_W-1:0] score_l_inc, score_r_inc;

    always_comb begin
        move_l      = L & ~R;
        move_r      = R & ~L;
        score_l_inc = (score_l_q == SCORE_MAX) ? score_l_q : score_l_q + 1'b1;
        score_r_inc = (score_r_q == SCORE_MAX) ? score_r_q : score_r_q + 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= StPlay;
            pos_q     <= CENTER;
            hold_q    <= '0;
            score_l_q <= '0;
            score_r_q <= '0;
            winner_q  <= 2'b00;
        end else if (restartGame) begin
            // Scores survive a restart unless the match is already decided.
            if (state_q == StMatch) begin
                score_l_q <= '0;
                score_r_q <= '0;
            end
            state_q  <= StPlay;
            pos_q    <= CENTER;
            hold_q   <= '0;
            winner_q <= 2'b00;
        end else begin
            unique case (state_q)
                StPlay: begin
                    if (move_l) begin
                        if (pos_q == LAST) begin
                            score_l_q <= score_l_inc;
                            winner_q  <= 2'b10;
                            if (score_l_inc == MATCH_V) begin
                                state_q <= StMatch;
                            end else begin
                                state_q <= StWon;
                                hold_q  <= HOLD_V;
                            end
                        end else begin
                            pos_q <= pos_q + 1'b1;
                        end
                    end else if (move_r) begin
                        if (pos_q == '0) begin
                            score_r_q <= score_r_inc;
                            winner_q  <= 2'b01;
                            if (score_r_inc == MATCH_V) begin
                                state_q <= StMatch;
                            end else begin
                                state_q <= StWon;
                                hold_q  <= HOLD_V;
                            end
                        end else begin
                            pos_q <= pos_q - 1'b1;
                        end
                    end
                end
                StWon: begin
                    hold_q <= hold_q - 1'b1;
                    if (hold_q == HOLD_ONE) begin
                        state_q  <= StPlay;
                        pos_q    <= CENTER;
                        winner_q <= 2'b00;
                    end
                end
                StMatch: begin
                end
                default: begin
                    state_q <= StPlay;
                    pos_q   <= CENTER;
                end
            endcase
        end
    end

    always_comb begin
        lights = '0;
        unique case (state_q)
            StPlay:  lights = NUM_LIGHTS'(1) << pos_q;
            StWon:   lights = '0;
            StMatch: lights = '1;
            default: lights = '0;
        endcase
    end

    assign winner    = winner_q;
    assign scoreL    = score_l_q;
    assign scoreR    = score_r_q;
    assign matchOver = (state_q == StMatch);

endmodule

// File: tb/tb_tug_field.sv
// Bench for tug_field: directed vector table, hand-written corner sequences, then random
// play checked against an integer model of the game rules.
module tb_tug_field;

    localparam int N  = 9;
    localparam int SW = 3;
    localparam int MP = 7;
    localparam int H  = 4;
    localparam int C  = (N - 1) / 2;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          L = 1'b0, R = 1'b0, restartGame = 1'b0;
    logic [N-1:0]  lights;
    logic [1:0]    winner;
    logic [SW-1:0] scoreL, scoreR;
    logic          matchOver;

    int n_cmp = 0;
    int n_bad = 0;

    tug_field #(
        .NUM_LIGHTS  (N),
        .SCORE_W     (SW),
        .MATCH_POINTS(MP),
        .HOLD_CYCLES (H)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .L          (L),
        .R          (R),
        .restartGame(restartGame),
        .lights     (lights),
        .winner     (winner),
        .scoreL     (scoreL),
        .scoreR     (scoreR),
        .matchOver  (matchOver)
    );

    always #5 Clock = ~Clock;

    // Game model: remaining hold cycles (0 = not holding), match flag, integer scores.
    int m_pos = C, m_sl = 0, m_sr = 0, m_hold = 0, m_win = 0;
    bit m_match = 1'b0;

    function automatic void model(input bit l, input bit r, input bit rg, input bit rst);
        if (rst) begin
            m_pos = C; m_sl = 0; m_sr = 0; m_hold = 0; m_win = 0; m_match = 0;
        end else if (rg) begin
            if (m_match) begin m_sl = 0; m_sr = 0; end
            m_match = 0; m_hold = 0; m_pos = C; m_win = 0;
        end else if (m_match) begin
        end else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) begin m_pos = C; m_win = 0; end
        end else if (l && !r) begin
            if (m_pos == N - 1) begin
                m_sl = (m_sl < (1 << SW) - 1) ? m_sl + 1 : m_sl;
                m_win = 2;
                if (m_sl == MP) m_match = 1; else m_hold = H;
            end else m_pos++;
        end else if (r && !l) begin
            if (m_pos == 0) begin
                m_sr = (m_sr < (1 << SW) - 1) ? m_sr + 1 : m_sr;
                m_win = 1;
                if (m_sr == MP) m_match = 1; else m_hold = H;
            end else m_pos--;
        end
    endfunction

    task automatic step(input bit l, input bit r, input bit rg, input bit rst);
        L = l; R = r; restartGame = rg; Reset = rst;
        @(posedge Clock);
        #1;
        model(l, r, rg, rst);
    endtask

    task automatic check(input string name, input logic [N-1:0] el, input logic [1:0] ew,
                         input logic [SW-1:0] esl, input logic [SW-1:0] esr, input logic emo);
        n_cmp++;
        if (lights !== el || winner !== ew || scoreL !== esl || scoreR !== esr
            || matchOver !== emo) begin
            n_bad++;
            $display("FAIL %s: got lights=%b win=%b sL=%0d sR=%0d mo=%b, want lights=%b win=%b sL=%0d sR=%0d mo=%b",
                     name, lights, winner, scoreL, scoreR, matchOver, el, ew, esl, esr, emo);
        end
    endtask

    task automatic check_model(input string name);
        logic [N-1:0] el;
        el = m_match ? {N{1'b1}} : (m_hold > 0 ? '0 : N'(1) << m_pos);
        check(name, el, 2'(m_win), SW'(m_sl), SW'(m_sr), m_match);
    endtask

    typedef struct packed {
        logic          rst, l, r, rg;
        logic [N-1:0]  lt;
        logic [1:0]    w;
        logic [SW-1:0] sl, sr;
        logic          mo;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic l, input logic r, input logic rg,
                                input logic [N-1:0] lt, input logic [1:0] w,
                                input logic [SW-1:0] sl, input logic [SW-1:0] sr);
        vec_t v;
        v.rst = rst; v.l = l; v.r = r; v.rg = rg;
        v.lt = lt; v.w = w; v.sl = sl; v.sr = sr; v.mo = 1'b0;
        vecs.push_back(v);
    endfunction

    initial begin
        // Reset and idle
        add(1, 0, 0, 0, 9'b000010000, 2'b00, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 9'b000010000, 2'b00, 0, 0);
        // Left pushes to the edge, then wins
        add(0, 1, 0, 0, 9'b000100000, 2'b00, 0, 0);
        add(0, 1, 0, 0, 9'b001000000, 2'b00, 0, 0);
        add(0, 1, 0, 0, 9'b010000000, 2'b00, 0, 0);
        add(0, 1, 0, 0, 9'b100000000, 2'b00, 0, 0);
        add(0, 1, 0, 0, 9'b000000000, 2'b10, 1, 0);
        // Presses during the hold are ignored; centre returns after exactly H cycles
        add(0, 1, 0, 0, 9'b000000000, 2'b10, 1, 0);
        add(0, 0, 1, 0, 9'b000000000, 2'b10, 1, 0);
        add(0, 0, 0, 0, 9'b000000000, 2'b10, 1, 0);
        add(0, 0, 0, 0, 9'b000010000, 2'b00, 1, 0);
        // Simultaneous presses are no move
        for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 9'b000010000, 2'b00, 1, 0);
        add(0, 0, 1, 0, 9'b000001000, 2'b00, 1, 0);
        add(0, 0, 1, 0, 9'b000000100, 2'b00, 1, 0);
        add(0, 0, 1, 0, 9'b000000010, 2'b00, 1, 0);
        add(0, 0, 1, 0, 9'b000000001, 2'b00, 1, 0);
        add(0, 0, 1, 0, 9'b000000000, 2'b01, 1, 1);

        foreach (vecs[i]) begin
            step(vecs[i].l, vecs[i].r, vecs[i].rg, vecs[i].rst);
            check($sformatf("vec%0d", i), vecs[i].lt, vecs[i].w, vecs[i].sl, vecs[i].sr,
                  vecs[i].mo);
        end

        // Right wins a full match from a clean reset
        step(0, 0, 0, 1);
        for (int rnd = 1; rnd <= MP; rnd++) begin
            for (int k = 0; k < C + 1; k++) step(0, 1, 0, 0);
            if (rnd < MP) for (int k = 0; k < H; k++) step(0, 0, 0, 0);
        end
        check("match_end", 9'h1FF, 2'b01, 3'd0, 3'd7, 1'b1);
        for (int k = 0; k < 6; k++) step(k[0], ~k[0], 0, 0);
        check("match_hold", 9'h1FF, 2'b01, 3'd0, 3'd7, 1'b1);
        step(0, 0, 1, 0);
        check("match_restart", 9'b000010000, 2'b00, 3'd0, 3'd0, 1'b0);

        // Restart two cycles into the hold keeps the score
        for (int k = 0; k < C + 1; k++) step(1, 0, 0, 0);
        check("win_l", 9'b000000000, 2'b10, 3'd1, 3'd0, 1'b0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        check("won_restart", 9'b000010000, 2'b00, 3'd1, 3'd0, 1'b0);
        step(0, 0, 0, 0);
        check("won_restart_stay", 9'b000010000, 2'b00, 3'd1, 3'd0, 1'b0);

        // Reset beats a winning press
        for (int k = 0; k < C; k++) step(1, 0, 0, 0);
        check("at_edge", 9'b100000000, 2'b00, 3'd1, 3'd0, 1'b0);
        step(1, 0, 0, 1);
        check("reset_vs_win", 9'b000010000, 2'b00, 3'd0, 3'd0, 1'b0);
        step(1, 0, 0, 0);
        check("play_after_reset", 9'b000100000, 2'b00, 3'd0, 3'd0, 1'b0);

        // Random play against the model
        step(0, 0, 0, 1);
        for (int i = 0; i < 4000; i++) begin
            bit l, r, rg, rst;
            l   = ($urandom_range(0, 9) < 5);
            r   = ($urandom_range(0, 9) < 4);
            rg  = ($urandom_range(0, 99) == 0);
            rst = ($urandom_range(0, 499) == 0);
            step(l, r, rg, rst);
            check_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
